// File: rtl/dmem_pkg.sv
// Shared constants, types and helpers for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 64;

    // Requester index; also the value stored in the round-robin pointer
    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_e;

    // Tag of the access issued last cycle, used to route its response
    typedef struct packed {
        logic  v;
        port_e port;
        logic  err;
    } rsp_tag_t;

    // Misaligned or beyond the last word: the access is accepted but never touches memory
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory-side bus of the arbiter.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    // Port 0: core load/store unit
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    // Port 1: DMA engine
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    // Single-port memory, registered read data
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    // Requesters and memory side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the port not granted last.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_e prio;
    port_e prio_next;

    // Grant decode and pointer update
    always_comb begin
        gnt       = 2'b00;
        prio_next = prio;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio == PORT_DMA) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            prio_next = PORT_DMA;
        end else if (gnt[1]) begin
            prio_next = PORT_CORE;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PORT_CORE;
        end else begin
            prio <= prio_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of a single-port data memory between core and DMA,
// with address checking and one-cycle response routing.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              fire;
    port_e             sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;
    rsp_tag_t          rsp_d;
    rsp_tag_t          rsp_q;

    assign req = {bus.p1_req, bus.p0_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.p0_gnt = gnt[0];
    assign bus.p1_gnt = gnt[1];
    assign fire       = |gnt;

    // Select the granted port's request; everything is zero when idle
    always_comb begin
        sel       = PORT_CORE;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (gnt)
            2'b01: begin
                sel       = PORT_CORE;
                sel_we    = bus.p0_we;
                sel_addr  = bus.p0_addr;
                sel_wdata = bus.p0_wdata;
            end
            2'b10: begin
                sel       = PORT_DMA;
                sel_we    = bus.p1_we;
                sel_addr  = bus.p1_addr;
                sel_wdata = bus.p1_wdata;
            end
            default: begin
                sel       = PORT_CORE;
                sel_we    = 1'b0;
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
        sel_bad = fire & addr_bad(sel_addr);
    end

    // Memory bus drive; a bad access is passed through but never writes
    always_comb begin
        bus.mem_we = sel_we & ~sel_bad;
        bus.mem_a  = sel_addr;
        bus.mem_wd = sel_wdata;
    end

    // Next response tag: valid exactly when an access fires this cycle
    always_comb begin
        rsp_d      = '0;
        rsp_d.v    = fire;
        rsp_d.port = sel;
        rsp_d.err  = sel_bad;
    end

    // Response tag register, loaded every cycle so idle cycles clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Route the memory read data back to the issuing port
    always_comb begin
        bus.p0_rvalid = 1'b0;
        bus.p0_err    = 1'b0;
        bus.p0_rdata  = '0;
        bus.p1_rvalid = 1'b0;
        bus.p1_err    = 1'b0;
        bus.p1_rdata  = '0;
        if (rsp_q.v) begin
            if (rsp_q.port == PORT_CORE) begin
                bus.p0_rvalid = 1'b1;
                bus.p0_err    = rsp_q.err;
                bus.p0_rdata  = rsp_q.err ? '0 : bus.mem_rd;
            end else begin
                bus.p1_rvalid = 1'b1;
                bus.p1_err    = rsp_q.err;
                bus.p1_rdata  = rsp_q.err ? '0 : bus.mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a response scoreboard.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic mem_clear = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port memory: reads old contents, then writes
    logic [31:0] mem [64];
    logic [31:0] mem_rd_q;
    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem_rd_q <= '0;
        end else begin
            if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
            mem_rd_q <= mem[bus.mem_a[7:2]];
        end
    end
    assign bus.mem_rd = mem_rd_q;

    typedef struct packed {
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
    } stim_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    localparam stim_t IDLE = '0;

    exp_t        sb [$];
    logic [31:0] shadow [64];
    logic        prio_m;
    int          checks = 0;
    int          passed = 0;

    task automatic apply(input stim_t s);
        bus.p0_req   = s.r0;
        bus.p0_we    = s.w0;
        bus.p0_addr  = s.a0;
        bus.p0_wdata = s.d0;
        bus.p1_req   = s.r1;
        bus.p1_we    = s.w1;
        bus.p1_addr  = s.a1;
        bus.p1_wdata = s.d1;
    endtask

    function automatic stim_t rd(input int p, input logic [31:0] a);
        stim_t s = '0;
        if (p == 0) begin s.r0 = 1'b1; s.a0 = a; end
        else        begin s.r1 = 1'b1; s.a1 = a; end
        return s;
    endfunction

    function automatic stim_t wr(input int p, input logic [31:0] a, input logic [31:0] d);
        stim_t s = '0;
        if (p == 0) begin s.r0 = 1'b1; s.w0 = 1'b1; s.a0 = a; s.d0 = d; end
        else        begin s.r1 = 1'b1; s.w1 = 1'b1; s.a1 = a; s.d1 = d; end
        return s;
    endfunction

    function automatic stim_t both(input stim_t s0, input stim_t s1);
        stim_t s = s0;
        s.r1 = s1.r1; s.w1 = s1.w1; s.a1 = s1.a1; s.d1 = s1.d1;
        return s;
    endfunction

    // Expected response vector {p0_rvalid,p0_err,p0_rdata,p1_rvalid,p1_err,p1_rdata}
    task automatic pop_exp(output logic [67:0] v);
        exp_t e;
        v = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) v = {34'b0, 1'b1, e.err, e.rdata};
            else        v = {1'b1, e.err, e.rdata, 34'b0};
        end
    endtask

    // Reference model: expected grant and memory bus for current inputs; queues the response
    task automatic model_fire(output logic [1:0] eg, output logic [64:0] em);
        logic        port;
        logic        we;
        logic        bad;
        logic [31:0] a;
        logic [31:0] d;
        exp_t        e;
        if (bus.p0_req && bus.p1_req) eg = prio_m ? 2'b10 : 2'b01;
        else                          eg = {bus.p1_req, bus.p0_req};
        em = '0;
        if (eg != 2'b00) begin
            port = eg[1];
            we   = port ? bus.p1_we    : bus.p0_we;
            a    = port ? bus.p1_addr  : bus.p0_addr;
            d    = port ? bus.p1_wdata : bus.p0_wdata;
            bad  = (a[1:0] != 2'b00) || (a >= 32'd256);
            e.port  = port;
            e.err   = bad;
            e.rdata = bad ? 32'h0 : shadow[a[7:2]];
            if (we && !bad) shadow[a[7:2]] = d;
            sb.push_back(e);
            em     = {we & ~bad, a, d};
            prio_m = ~port;
        end
    endtask

    function automatic logic [67:0] obs_rsp();
        return {bus.p0_rvalid, bus.p0_err, bus.p0_rdata, bus.p1_rvalid, bus.p1_err, bus.p1_rdata};
    endfunction

    function automatic logic [64:0] obs_mem();
        return {bus.mem_we, bus.mem_a, bus.mem_wd};
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        apply(IDLE);
        sb.delete();
        prio_m = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply(IDLE);
        #1;
        checks++;
        if (obs_rsp() !== 68'h0) $display("FAIL reset_rsp: got %h expected 0", obs_rsp());
        else passed++;
        checks++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b00)
            $display("FAIL reset_gnt: got %b expected 00", {bus.p1_gnt, bus.p0_gnt});
        else passed++;
        checks++;
        if (obs_mem() !== 65'h0) $display("FAIL reset_mem: got %h expected 0", obs_mem());
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs_rsp() !== 68'h0) $display("FAIL reset_release_rsp: got %h expected 0", obs_rsp());
        else passed++;
    endtask

    task automatic test_write_read();
        stim_t       st [$];
        logic [67:0] ev;
        logic [1:0]  eg;
        logic [64:0] em;
        st = '{wr(0, 32'h10, 32'hDEADBEEF), rd(0, 32'h10), IDLE};
        foreach (st[i]) begin
            apply(st[i]); #1;
            pop_exp(ev); checks++;
            if (obs_rsp() !== ev) $display("FAIL wr_rd_rsp[%0d]: got %h expected %h", i, obs_rsp(), ev);
            else passed++;
            model_fire(eg, em); checks++;
            if ({bus.p1_gnt, bus.p0_gnt} !== eg)
                $display("FAIL wr_rd_gnt[%0d]: got %b expected %b", i, {bus.p1_gnt, bus.p0_gnt}, eg);
            else passed++;
            checks++;
            if (obs_mem() !== em) $display("FAIL wr_rd_mem[%0d]: got %h expected %h", i, obs_mem(), em);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        stim_t       st [$];
        logic [67:0] ev;
        logic [1:0]  eg;
        logic [64:0] em;
        logic [1:0]  alt;
        reset_dut();
        for (int i = 0; i < 6; i++) st.push_back(both(rd(0, 32'h10), rd(1, 32'h14)));
        st.push_back(IDLE);
        foreach (st[i]) begin
            apply(st[i]); #1;
            pop_exp(ev); checks++;
            if (obs_rsp() !== ev) $display("FAIL contend_rsp[%0d]: got %h expected %h", i, obs_rsp(), ev);
            else passed++;
            model_fire(eg, em); checks++;
            if ({bus.p1_gnt, bus.p0_gnt} !== eg)
                $display("FAIL contend_gnt[%0d]: got %b expected %b", i, {bus.p1_gnt, bus.p0_gnt}, eg);
            else passed++;
            if (i < 6) begin
                alt = (i % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if ({bus.p1_gnt, bus.p0_gnt} !== alt)
                    $display("FAIL contend_alt[%0d]: got %b expected %b", i, {bus.p1_gnt, bus.p0_gnt}, alt);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bad_access();
        stim_t       st [$];
        logic [67:0] ev;
        logic [1:0]  eg;
        logic [64:0] em;
        st = '{wr(0, 32'h00, 32'h55AA55AA), wr(0, 32'h04, 32'h11111111),
               wr(1, 32'h104, 32'hCAFEF00D), rd(1, 32'h02), wr(1, 32'h05, 32'hBADBAD00),
               rd(0, 32'h00), rd(0, 32'h04), IDLE};
        foreach (st[i]) begin
            apply(st[i]); #1;
            pop_exp(ev); checks++;
            if (obs_rsp() !== ev) $display("FAIL bad_rsp[%0d]: got %h expected %h", i, obs_rsp(), ev);
            else passed++;
            model_fire(eg, em); checks++;
            if ({bus.p1_gnt, bus.p0_gnt} !== eg)
                $display("FAIL bad_gnt[%0d]: got %b expected %b", i, {bus.p1_gnt, bus.p0_gnt}, eg);
            else passed++;
            checks++;
            if (obs_mem() !== em) $display("FAIL bad_mem[%0d]: got %h expected %h", i, obs_mem(), em);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_resp();
        stim_t       st [$];
        logic [67:0] ev;
        logic [1:0]  eg;
        logic [64:0] em;
        st = '{wr(0, 32'h14, 32'h11), wr(1, 32'h14, 32'h22), rd(1, 32'h14), IDLE};
        foreach (st[i]) begin
            apply(st[i]); #1;
            pop_exp(ev); checks++;
            if (obs_rsp() !== ev) $display("FAIL wresp_rsp[%0d]: got %h expected %h", i, obs_rsp(), ev);
            else passed++;
            model_fire(eg, em); checks++;
            if (obs_mem() !== em) $display("FAIL wresp_mem[%0d]: got %h expected %h", i, obs_mem(), em);
            else passed++;
            @(posedge clk); #1;
        end
        checks++;
        if (shadow[5] !== 32'h22) $display("FAIL wresp_model: got %h expected 00000022", shadow[5]);
        else passed++;
    endtask

    task automatic test_back_to_back_p1();
        stim_t       st [$];
        logic [67:0] ev;
        logic [1:0]  eg;
        logic [64:0] em;
        for (int i = 0; i < 3; i++) st.push_back(rd(1, 32'h00));
        for (int i = 0; i < 3; i++) st.push_back(both(rd(0, 32'h10), rd(1, 32'h14)));
        st.push_back(IDLE);
        foreach (st[i]) begin
            apply(st[i]); #1;
            pop_exp(ev); checks++;
            if (obs_rsp() !== ev) $display("FAIL p1_alone_rsp[%0d]: got %h expected %h", i, obs_rsp(), ev);
            else passed++;
            model_fire(eg, em); checks++;
            if ({bus.p1_gnt, bus.p0_gnt} !== eg)
                $display("FAIL p1_alone_gnt[%0d]: got %b expected %b", i, {bus.p1_gnt, bus.p0_gnt}, eg);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t       st [$];
        logic [67:0] ev;
        logic [1:0]  eg;
        logic [64:0] em;
        apply(rd(0, 32'h10)); #1;
        model_fire(eg, em); checks++;
        if ({bus.p1_gnt, bus.p0_gnt} !== eg)
            $display("FAIL rstmid_fire: got %b expected %b", {bus.p1_gnt, bus.p0_gnt}, eg);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        apply(IDLE);
        sb.delete();
        prio_m = 1'b0;
        #1;
        checks++;
        if (obs_rsp() !== 68'h0) $display("FAIL rstmid_in_reset: got %h expected 0", obs_rsp());
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        st = '{IDLE, both(rd(0, 32'h10), rd(1, 32'h14)), both(rd(0, 32'h10), rd(1, 32'h14)), IDLE};
        foreach (st[i]) begin
            apply(st[i]); #1;
            pop_exp(ev); checks++;
            if (obs_rsp() !== ev) $display("FAIL rstmid_rsp[%0d]: got %h expected %h", i, obs_rsp(), ev);
            else passed++;
            model_fire(eg, em); checks++;
            if ({bus.p1_gnt, bus.p0_gnt} !== eg)
                $display("FAIL rstmid_gnt[%0d]: got %b expected %b", i, {bus.p1_gnt, bus.p0_gnt}, eg);
            else passed++;
            checks++;
            if (obs_mem() !== em) $display("FAIL rstmid_mem[%0d]: got %h expected %h", i, obs_mem(), em);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply(IDLE);
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        prio_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        test_reset();
        test_write_read();
        test_contention();
        test_bad_access();
        test_write_resp();
        test_back_to_back_p1();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
